// File: rtl/fetch_line_buffer_if.sv
// Memory request/reply channel between a fetch master and instruction memory.
// Read channel is a valid/ready request (raddr) plus a valid/ready reply (rdata).
interface Mem_ift #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              r_request_valid;
    logic              r_request_ready;
    logic [ADDR_W-1:0] raddr;
    logic              r_reply_valid;
    logic              r_reply_ready;
    logic [DATA_W-1:0] rdata;
    logic              w_request_valid;
    logic              w_request_ready;
    logic              w_reply_valid;
    logic              w_reply_ready;

    modport Master (
        output r_request_valid, raddr, r_reply_ready, w_request_valid, w_reply_ready,
        input  r_request_ready, r_reply_valid, rdata, w_request_ready, w_reply_valid
    );
    modport Slave (
        input  r_request_valid, raddr, r_reply_ready, w_request_valid, w_reply_ready,
        output r_request_ready, r_reply_valid, rdata, w_request_ready, w_reply_valid
    );
endinterface

// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer: serves hits from one 64-bit line, fills on miss.
// Optional FETCH_BYPASS_EN forwards the reply data to the core in the reply cycle.
module fetch_line_buffer #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_req,
    input  logic              inv,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              stall,
    output logic [31:0]       miss_cnt,
    Mem_ift.Master            imem_ift
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nxt;
    logic [1:0][31:0]  line;
    logic [ADDR_W-4:0] tag;
    logic              line_valid;
    logic              discard;
    logic [ADDR_W-1:0] req_addr;
    logic              hit, miss, fill;
    logic              unused_sig;

    assign hit  = fetch_req & line_valid & (tag == pc[ADDR_W-1:3]);
    assign miss = (state == IDLE) & fetch_req & ~hit;
    assign fill = (state == WAIT) & imem_ift.r_reply_valid;

    assign unused_sig = ^{pc[1:0], imem_ift.w_request_ready, imem_ift.w_reply_valid};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss) state_nxt = REQ;
            REQ:     if (imem_ift.r_request_ready) state_nxt = WAIT;
            WAIT:    if (imem_ift.r_reply_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line       <= '0;
            tag        <= '0;
            line_valid <= 1'b0;
            discard    <= 1'b0;
            req_addr   <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inv) line_valid <= 1'b0;
                    if (miss) begin
                        req_addr <= {pc[ADDR_W-1:3], 3'b000};
                        discard  <= 1'b0;
                    end
                end
                REQ: if (inv) discard <= 1'b1;
                WAIT: begin
                    if (inv) discard <= 1'b1;
                    // An inv landing with the reply still kills the fill.
                    if (fill) begin
                        line       <= imem_ift.rdata;
                        tag        <= req_addr[ADDR_W-1:3];
                        line_valid <= ~(discard | inv);
                        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        inst       = pc[2] ? line[1] : line[0];
        inst_valid = (state == IDLE) & hit;
`ifdef FETCH_BYPASS_EN
        if (fill & ~discard & (req_addr[ADDR_W-1:3] == pc[ADDR_W-1:3])) begin
            inst       = pc[2] ? imem_ift.rdata[63:32] : imem_ift.rdata[31:0];
            inst_valid = 1'b1;
        end
`endif
    end

    assign stall = fetch_req & ~inst_valid;

    assign imem_ift.r_request_valid = (state == REQ);
    assign imem_ift.raddr           = req_addr;
    assign imem_ift.r_reply_ready   = (state == WAIT);
    assign imem_ift.w_request_valid = 1'b0;
    assign imem_ift.w_reply_ready   = 1'b1;
endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Single-line instruction fetch buffer between the core's instruction-fetch port and instruction memory. Holds one 64-bit aligned fetch line (two 32-bit instructions), serves hits combinationally, and on a miss runs a request/reply handshake on `Mem_ift`, stalling the core until the line arrives. Removes the redundant memory read for the second instruction of each 8-byte line and lets the core tolerate multi-cycle instruction memory.

## Interface
Parameters:
- `ADDR_W`, 64, address width; must match `CorePack::addr_t`.
- `LINE_W`, 64, fetch line width; fixed at 64, i.e. two instructions per line.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserted when 0.
- `pc`  in  64  current fetch PC; bits [1:0] ignored.
- `fetch_req`  in  1  core wants an instruction this cycle.
- `inv`  in  1  one-cycle pulse that invalidates the buffered line.
- `inst`  out  32  instruction. `line[63:32]` when `pc[2]`=1, else `line[31:0]`.
- `inst_valid`  out  1  `inst` is valid for `pc` this cycle.
- `stall`  out  1  equals `fetch_req & ~inst_valid`.
- `miss_cnt`  out  32  count of line fills. Saturates at 0xFFFF_FFFF.
- `imem_ift`  Mem_ift.Master  –  memory-side read channel. The write channel is tied off: `w_request_valid`=0 and `w_reply_ready`=1.

## Operation
- State: `line` (64 bits), `tag` (`pc[63:3]`), `line_valid`, `req_addr` (64 bits), `discard` (1 bit), and the FSM.
- Hit: `fetch_req & line_valid & (tag == pc[63:3])`. On a hit, `inst_valid`=1 in the same cycle, with no memory traffic.
- FSM `IDLE`:
  - Stays in `IDLE` on a hit, or when `fetch_req`=0.
  - On a miss, latches `req_addr = {pc[63:3], 3'b0}`, clears `discard`, and goes to `REQ`.
- FSM `REQ`:
  - Drives `r_request_valid`=1 and `raddr=req_addr`.
  - Holds both stable until `r_request_ready`=1, then goes to `WAIT`.
- FSM `WAIT`:
  - Drives `r_reply_ready`=1.
  - On `r_reply_valid`:
    - Captures `rdata` into `line`, and `req_addr[63:3]` into `tag`.
    - Sets `line_valid = ~discard`.
    - Increments `miss_cnt`, saturating.
    - Goes to `IDLE`.
- `r_request_valid` is 0 outside `REQ`. `r_reply_ready` is 0 outside `WAIT`.
- `inv`:
  - In `IDLE`, clears `line_valid` at the next edge.
  - In `REQ` or `WAIT`, sets `discard`. The transaction still completes; the filled line stays invalid.
- PC change during `REQ`/`WAIT` (branch redirect): the outstanding transaction is never cancelled. The fill completes, then `IDLE` re-evaluates hit/miss against the new `pc`.
- Same-cycle `inv` and reply in `WAIT`: the line is discarded.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM=`IDLE`; `line_valid`=0, `discard`=0, `miss_cnt`=0, `line`=0, `tag`=0, `req_addr`=0.
  - Outputs: `inst`=0 (line cleared), `inst_valid`=0, `stall`=`fetch_req`, `r_request_valid`=0, `r_reply_ready`=0.
- Reset mid-transaction: the FSM returns to `IDLE`. The memory shares `rst` and drops its own pending state.
- Hit latency: 0 cycles (combinational from `pc`).
- Miss latency, with memory `ready`=1 and reply one cycle after accept:
  - Cycle 0: miss detected.
  - Cycle 1: `REQ`, accepted.
  - Cycle 2: `WAIT`, reply.
  - Cycle 3: `IDLE` hit.
  - Total: 3 stall cycles. Each extra wait cycle on `ready` or `reply_valid` adds exactly one stall cycle.
- `miss_cnt` updates at the edge that ends `WAIT`.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - In `WAIT`, when `r_reply_valid`=1, `~discard`, and `req_addr[63:3] == pc[63:3]`, drive `inst_valid`=1 in that cycle.
  - `inst` is taken from `rdata`, selected by `pc[2]`.
  - Minimum miss penalty becomes 2 stall cycles.
- Undefined: no forwarding. `inst_valid` is asserted only from the registered line, in `IDLE`.
- Register state updates are identical in both configurations.

## Test plan
- Reset, then `pc`=0x0, `fetch_req`=1, memory returns 0x00500093_00100073 (`ready`=1, 1-cycle reply).
  - `stall`=1 for 3 cycles.
  - Then `inst`=0x00100073.
  - `pc`=0x4 then gives `inst`=0x00500093 with `stall`=0, and no new request.
  - `miss_cnt`=1.
- `pc`=0x8 after the above: new request with `raddr`=0x8; `miss_cnt`=2. Returning to `pc`=0x0 refetches (single line held); `miss_cnt`=3.
- Memory holds `r_request_ready`=0 for 4 cycles:
  - `r_request_valid` and `raddr` stay stable throughout.
  - Stall lasts 7 cycles.
- `inv` pulsed in `WAIT` with `pc`=0x10: reply accepted, `line_valid` stays 0, a second request to 0x10 follows; `miss_cnt`=2.
- `rst` driven to 0 asynchronously in `WAIT`:
  - `r_reply_ready`, `line_valid`, and `miss_cnt` go to 0 immediately.
  - After release, the same `pc` misses again.
- With `FETCH_BYPASS_EN`, the first scenario shows `inst_valid`=1 in the reply cycle, with `inst`=0x00100073 and 2 stall cycles.
